regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW, default 32, data word width in bits.
REQ-002 Parameter AW, default 5, register address width; register count NREG = 2**AW.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 rna  input  AW  read port A register number.
REQ-006 rnb  input  AW  read port B register number.
REQ-007 qa  output  DW  read port A data (combinational).
REQ-008 qb  output  DW  read port B data (combinational).
REQ-009 we  input  1  writeback enable.
REQ-010 wn  input  AW  writeback register number.
REQ-011 d  input  DW  writeback data.
REQ-012 iss_v  input  1  issue valid: an instruction producing register iss_wn enters the pipeline.
REQ-013 iss_wn  input  AW  destination register of the issuing instruction.
REQ-014 busy_a  output  1  source A has an outstanding, not-yet-forwardable write.
REQ-015 busy_b  output  1  source B has an outstanding, not-yet-forwardable write.
REQ-016 npend  output  AW+1  count of registers currently marked busy.

Function
REQ-017 Register 0 SHALL read as 0, ignore writes, never be marked busy.
REQ-018 Storage SHALL hold NREG-1 words of DW bits (registers 1..NREG-1).
REQ-019 Write: on rising clk with we=1 and wn!=0, register[wn] <= d; one-cycle latency to storage.
REQ-020 Bypass: qa SHALL equal d when we=1, wn!=0, wn==rna; else register[rna] (0 if rna==0); qb likewise with rnb.
REQ-021 Scoreboard: per-register busy bit; on rising clk, busy[iss_wn] <= 1 when iss_v=1 and iss_wn!=0.
REQ-022 On rising clk, busy[wn] <= 0 when we=1 and wn!=0, unless the set condition of REQ-021 targets the same register that cycle.
REQ-023 Simultaneous set and clear of the same register: set wins (busy stays/becomes 1).
REQ-024 Set of an already-busy register: busy stays 1, npend unchanged.
REQ-025 Clear of a non-busy register (writeback without issue): data written, busy stays 0, npend unchanged.
REQ-026 busy_a = busy[rna] AND NOT (we=1 AND wn==rna); rna==0 gives busy_a=0; busy_b likewise with rnb.
REQ-027 npend SHALL equal the population count of busy bits after each edge; updated +1, -1, or 0 per cycle; never wraps (max NREG-1, min 0).
REQ-028 Set and clear to different registers in the same cycle: both applied, npend unchanged.
REQ-029 No other state or output SHALL change between rising edges except via clrn.

Reset
REQ-030 clrn=0 SHALL immediately, independent of clk, clear all registers to 0, all busy bits to 0, npend to 0.
REQ-031 While clrn=0, writes and issues SHALL be ignored; qa/qb SHALL reflect zeroed storage except that the bypass path of REQ-020 remains active.
REQ-032 Reset asserted mid-operation SHALL discard all pending busy marks; first edge after clrn rises operates normally.

Verification
REQ-033 Reset, then we=1 wn=5 d=32'h1234_5678 one cycle; next cycle rna=5 -> qa=32'h1234_5678, busy_a=0.
REQ-034 Same-cycle bypass: we=1 wn=7 d=32'hDEAD_BEEF, rna=7, rnb=7 -> qa=qb=32'hDEAD_BEEF before the edge.
REQ-035 we=1 wn=0 d=32'hFFFF_FFFF; iss_v=1 iss_wn=0; rna=0 -> qa=0, busy_a=0, npend=0.
REQ-036 iss_v=1 iss_wn=3; next cycle rna=3 -> busy_a=1, npend=1; then we=1 wn=3 d=9 -> busy_a=0 and qa=9 same cycle; after edge npend=0.
REQ-037 busy[4]=1; same cycle iss_v=1 iss_wn=4 and we=1 wn=4 -> after edge busy[4]=1, npend=1, register[4]=d.
REQ-038 Issue to registers 1,2,3 (npend=3), pulse clrn=0 between edges -> npend=0, busy_a=busy_b=0, all reads 0 immediately.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read/one-write register file with writeback bypass and issue scoreboard
// Register 0 is hardwired to zero and never tracked by the scoreboard.
module regfile_sb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          we,
    input  logic [AW-1:0] wn,
    input  logic [DW-1:0] d,
    input  logic          iss_v,
    input  logic [AW-1:0] iss_wn,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   npend
);
    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   regs [1:NREG-1];
    logic [NREG-1:1] busy;
    logic [NREG-1:0] busy_all;
    logic            wr;
    logic            set;
    logic            inc;
    logic            dec;

    assign busy_all = {busy, 1'b0};
    assign wr       = we && (wn != '0);
    assign set      = iss_v && (iss_wn != '0);

    // Count only real transitions; a set to the register being cleared wins.
    assign inc = set && !busy_all[iss_wn];
    assign dec = wr && busy_all[wn] && !(set && (iss_wn == wn));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[wn] <= d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (set && (iss_wn == AW'(i)))
                    busy[i] <= 1'b1;
                else if (wr && (wn == AW'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            npend <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   npend <= npend + 1'b1;
                2'b01:   npend <= npend - 1'b1;
                default: npend <= npend;
            endcase
        end
    end

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
        return regs[a];
    endfunction

    // The writeback bypass stays live even while clrn holds storage at zero.
    assign qa = (wr && (wn == rna)) ? d : rd(rna);
    assign qb = (wr && (wn == rnb)) ? d : rd(rnb);

    assign busy_a = busy_all[rna] && !(we && (wn == rna));
    assign busy_b = busy_all[rnb] && !(we && (wn == rnb));
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and random checks of regfile_sb against an array-based model
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  rna, rnb, wn, iss_wn;
    logic [31:0] qa, qb, d;
    logic        we, iss_v, busy_a, busy_b;
    logic [5:0]  npend;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    logic        mbusy [32];

    regfile_sb #(.DW(32), .AW(5)) dut (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .we(we), .wn(wn), .d(d), .iss_v(iss_v), .iss_wn(iss_wn),
        .busy_a(busy_a), .busy_b(busy_b), .npend(npend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    function automatic int pop();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic logic [31:0] exp_q(input logic [4:0] a);
        if (we && wn != 0 && wn == a) return d;
        return mregs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return mbusy[a] && !(we && wn == a);
    endfunction

    task automatic check_model();
        chk("qa", 64'(qa), 64'(exp_q(rna)));
        chk("qb", 64'(qb), 64'(exp_q(rnb)));
        chk("busy_a", 64'(busy_a), 64'(exp_busy(rna)));
        chk("busy_b", 64'(busy_b), 64'(exp_busy(rnb)));
        chk("npend", 64'(npend), 64'(pop()));
    endtask

    task automatic drive(input logic w, input logic [4:0] n, input logic [31:0] dd,
                         input logic iv, input logic [4:0] iw,
                         input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        we = w; wn = n; d = dd; iss_v = iv; iss_wn = iw; rna = a; rnb = b;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        if (clrn) begin
            if (we && wn != 0) begin
                mregs[wn] = d;
                mbusy[wn] = 1'b0;
            end
            if (iss_v && iss_wn != 0) mbusy[iss_wn] = 1'b1;
        end
    endtask

    initial begin
        clrn = 1'b0;
        we = 0; wn = 0; d = 0; iss_v = 0; iss_wn = 0; rna = 0; rnb = 0;
        model_reset();

        drive(0, 0, 0, 0, 0, 1, 31);
        chk("reset_npend", 64'(npend), 64'd0);
        clrn = 1'b1;
        tick();

        drive(1, 5, 32'h1234_5678, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 0);
        chk("wr_read_qa", 64'(qa), 64'h1234_5678);
        chk("wr_read_busy", 64'(busy_a), 64'd0);
        tick();

        drive(1, 7, 32'hDEAD_BEEF, 0, 0, 7, 7);
        chk("bypass_qa", 64'(qa), 64'hDEAD_BEEF);
        chk("bypass_qb", 64'(qb), 64'hDEAD_BEEF);
        tick();

        drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        chk("r0_qa", 64'(qa), 64'd0);
        chk("r0_busy", 64'(busy_a), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_npend", 64'(npend), 64'd0);

        drive(0, 0, 0, 1, 3, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        chk("iss3_busy", 64'(busy_a), 64'd1);
        chk("iss3_npend", 64'(npend), 64'd1);
        tick();
        drive(1, 3, 32'd9, 0, 0, 3, 0);
        chk("wb3_busy", 64'(busy_a), 64'd0);
        chk("wb3_qa", 64'(qa), 64'd9);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        chk("wb3_npend", 64'(npend), 64'd0);

        drive(0, 0, 0, 1, 4, 0, 0);
        tick();
        drive(1, 4, 32'hA5, 1, 4, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 4, 0);
        chk("setwins_busy", 64'(busy_a), 64'd1);
        chk("setwins_npend", 64'(npend), 64'd1);
        chk("setwins_data", 64'(qa), 64'hA5);
        tick();
        drive(1, 4, 0, 0, 0, 0, 0);
        tick();

        for (int r = 1; r <= 3; r++) begin
            drive(0, 0, 0, 1, 5'(r), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 2);
        chk("pend3", 64'(npend), 64'd3);
        clrn = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("rst_npend", 64'(npend), 64'd0);
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_busy_b", 64'(busy_b), 64'd0);
        chk("rst_qa", 64'(qa), 64'd0);
        clrn = 1'b1;
        tick();

        @(negedge clk);
        clrn = 1'b0;
        model_reset();
        drive(1, 9, 32'h55, 1, 9, 9, 0);
        chk("rst_bypass", 64'(qa), 64'h55);
        tick();
        drive(0, 0, 0, 0, 0, 9, 0);
        chk("rst_nowrite", 64'(qa), 64'd0);
        chk("rst_noissue", 64'(npend), 64'd0);
        clrn = 1'b1;
        tick();

        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                clrn = 1'b0;
                #1;
                model_reset();
                check_model();
                clrn = 1'b1;
                #1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
